// File: rtl/icache_l1_nway_if.sv
// Fetch-side and memory-side bundles for the N-way L1 instruction cache.
// The cache is the slave of the fetch port and the master of the memory port.
interface icache_cpu_if #(
  parameter int ADDR_SIZE = 14,
  parameter int WORD_SIZE = 32
);
  logic                 flush;
  logic                 cpu_re;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_dout;
  logic                 cpu_hit;
  logic                 cpu_stall;

  modport master (
    output flush, cpu_re, cpu_addr,
    input  cpu_dout, cpu_hit, cpu_stall
  );
  modport slave (
    input  flush, cpu_re, cpu_addr,
    output cpu_dout, cpu_hit, cpu_stall
  );
endinterface

interface icache_mem_if #(
  parameter int ADDR_SIZE = 14,
  parameter int WORD_SIZE = 32
);
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/icache_l1_nway.sv
// N-way set-associative read-only L1 I-cache: combinational lookup,
// line-burst refill FSM, per-set round-robin replacement preferring invalid ways.
module icache_l1_nway #(
  parameter int ADDR_SIZE      = 14,
  parameter int WORD_SIZE      = 32,
  parameter int SETS           = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int WAYS           = 4
) (
  input logic          clk,
  input logic          reset,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem
);
  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_SIZE - OFF - IDX;
  localparam int WB  = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WORD_SIZE-1:0] data_q [WAYS][SETS][WORDS_PER_LINE];
  logic [TAG-1:0]       tag_q  [WAYS][SETS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WB-1:0]        rr_q    [SETS];

  logic [TAG+IDX-1:0] line_q;
  logic [WB-1:0]      victim_q;
  logic [OFF-1:0]     beat_q;
  logic               flush_pend;

  logic [OFF-1:0] off;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [IDX-1:0] fidx;
  logic [TAG-1:0] ftag;

  assign off  = cpu.cpu_addr[OFF-1:0];
  assign idx  = cpu.cpu_addr[OFF+IDX-1:OFF];
  assign tag  = cpu.cpu_addr[ADDR_SIZE-1:OFF+IDX];
  assign fidx = line_q[IDX-1:0];
  assign ftag = line_q[TAG+IDX-1:IDX];

  logic [WAYS-1:0]      match;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WB-1:0]        victim;
  logic                 hit;
  logic                 miss_go;
  logic                 beat_ok;
  logic                 last_beat;
  logic                 req;

  always_comb begin
    match   = '0;
    rd_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
      if (match[w]) rd_word = rd_word | data_q[w][idx][off];
    end
  end

  // lowest-index invalid way wins, otherwise the set's round-robin pointer
  always_comb begin
    victim = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WB'(w);
    end
  end

  assign hit       = cpu.cpu_re && (state == IDLE) && $onehot(match);
  assign miss_go   = (state == IDLE) && cpu.cpu_re && !hit && !cpu.flush;
  assign beat_ok   = (state == FILL) && mem.mem_rvalid;
  assign last_beat = beat_ok && (&beat_q);

  assign cpu.cpu_hit   = hit;
  assign cpu.cpu_dout  = hit ? rd_word : '0;
  assign cpu.cpu_stall = (cpu.cpu_re && !hit) || (state != IDLE) || flush_pend;

  assign mem.mem_req  = req;
  assign mem.mem_addr = req ? {line_q, {OFF{1'b0}}} : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_go) state_nx = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (mem.mem_gnt) state_nx = FILL;
      end
      FILL: begin
        if (last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q     <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end else if (miss_go) begin
            line_q               <= {tag, idx};
            victim_q             <= victim;
            valid_q[idx][victim] <= 1'b0;
          end
        end
        REQ: begin
          if (cpu.flush)   flush_pend <= 1'b1;
          if (mem.mem_gnt) beat_q     <= '0;
        end
        FILL: begin
          if (cpu.flush) flush_pend <= 1'b1;
          if (beat_ok)   beat_q     <= beat_q + 1'b1;
          // a flush seen during the burst also kills the line just filled
          if (last_beat) begin
            rr_q[fidx] <= victim_q + 1'b1;
            flush_pend <= 1'b0;
            if (flush_pend || cpu.flush) begin
              for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else begin
              valid_q[fidx][victim_q] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && beat_ok) begin
      data_q[victim_q][fidx][beat_q] <= mem.mem_rdata;
      if (&beat_q) tag_q[victim_q][fidx] <= ftag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert ($onehot0(match));
  end

endmodule

// File: tb/tb_icache_l1_nway.sv
// Bench for icache_l1_nway: vector table for hit streams, hand-driven
// refill bursts for miss, eviction, flush and reset corner cases.
module tb_icache_l1_nway;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_cpu_if cif ();
  icache_mem_if mif ();

  icache_l1_nway dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cif),
    .mem   (mif)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic        hit;
    logic [31:0] dout;
    logic        stall;
  } exp_t;

  typedef struct {
    logic        re;
    logic [13:0] addr;
    logic        hit;
    logic [31:0] dout;
    logic        stall;
  } vec_t;

  exp_t sb[$];
  vec_t tv[10];

  function automatic logic [31:0] beat(input logic [13:0] base, input int k);
    logic [5:0] t;
    t = base[13:8];
    return 32'hA0 + 32'(k) + (32'(t) << 16);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_hit"},   32'(cif.cpu_hit),   32'(e.hit));
      chk({e.nm, "_dout"},  cif.cpu_dout,       e.dout);
      chk({e.nm, "_stall"}, 32'(cif.cpu_stall), 32'(e.stall));
    end
  endtask

  task automatic lookup(input string nm, input logic re, input logic [13:0] a,
                        input logic h, input logic [31:0] d, input logic st);
    cif.cpu_re   = re;
    cif.cpu_addr = a;
    sb.push_back('{nm, h, d, st});
    #1;
    score();
  endtask

  task automatic miss(input string nm, input logic [13:0] a);
    lookup(nm, 1'b1, a, 1'b0, 32'd0, 1'b1);
    cyc();
  endtask

  // entered one cycle after the missing lookup, with the DUT in REQ
  task automatic fill(input logic [13:0] base, input int gdly, input int gap,
                      input int fl_beat, input int rst_beat);
    for (int d = 0; d <= gdly; d++) begin
      mif.mem_gnt    = (d == gdly);
      mif.mem_rvalid = (d > 0);
      mif.mem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("req",       32'(mif.mem_req),  32'd1);
      chk("req_addr",  32'(mif.mem_addr), 32'(base));
      chk("req_nohit", 32'(cif.cpu_hit),  32'd0);
      cyc();
    end
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("gap_nohit", 32'(cif.cpu_hit), 32'd0);
        chk("gap_noreq", 32'(mif.mem_req), 32'd0);
        cyc();
      end
      mif.mem_rvalid = 1'b1;
      mif.mem_rdata  = beat(base, k);
      cif.flush      = (k == fl_beat);
      reset          = (k == rst_beat);
      #1;
      chk("fill_stall", 32'(cif.cpu_stall), 32'd1);
      cyc();
      mif.mem_rvalid = 1'b0;
      cif.flush      = 1'b0;
      if (k == rst_beat) return;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] b;

    for (int k = 0; k < 8; k++)
      tv[k] = '{1'b1, 14'h0040 + 14'(k), 1'b1, 32'hA0 + 32'(k), 1'b0};
    tv[8] = '{1'b0, 14'h0043, 1'b0, 32'd0, 1'b0};
    tv[9] = '{1'b1, 14'h0047, 1'b1, 32'hA7, 1'b0};

    reset          = 1'b1;
    cif.flush      = 1'b0;
    cif.cpu_re     = 1'b0;
    cif.cpu_addr   = '0;
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_req",   32'(mif.mem_req),   32'd0);
    chk("rst_addr",  32'(mif.mem_addr),  32'd0);
    chk("rst_hit",   32'(cif.cpu_hit),   32'd0);
    chk("rst_stall", 32'(cif.cpu_stall), 32'd0);
    chk("rst_dout",  cif.cpu_dout,       32'd0);
    cyc();

    miss("cold", 14'h0043);
    fill(14'h0040, 1, 0, -1, -1);
    lookup("cold_hit", 1'b1, 14'h0043, 1'b1, 32'hA3, 1'b0);
    cyc();

    foreach (tv[i]) begin
      lookup($sformatf("tv%0d", i), tv[i].re, tv[i].addr,
             tv[i].hit, tv[i].dout, tv[i].stall);
      chk("tv_noreq", 32'(mif.mem_req), 32'd0);
      cyc();
    end

    for (int t = 1; t < 4; t++) begin
      b = 14'h0040 | 14'(t << 8);
      miss("set8", b + 14'd2);
      fill(b, 0, 0, -1, -1);
    end
    for (int t = 0; t < 4; t++) begin
      b = 14'h0040 | 14'(t << 8);
      lookup("set8_hit", 1'b1, b + 14'd5, 1'b1, beat(b, 5), 1'b0);
      cyc();
    end
    miss("evict", 14'h0441);
    fill(14'h0440, 0, 0, -1, -1);
    lookup("tag4_hit", 1'b1, 14'h0446, 1'b1, beat(14'h0440, 6), 1'b0);
    cyc();
    lookup("tag1_hit", 1'b1, 14'h0140, 1'b1, beat(14'h0140, 0), 1'b0);
    cyc();
    miss("tag0_evicted", 14'h0040);
    fill(14'h0040, 0, 0, -1, -1);
    lookup("tag0_back", 1'b1, 14'h0043, 1'b1, 32'hA3, 1'b0);
    cyc();
    lookup("tag2_kept", 1'b1, 14'h0247, 1'b1, beat(14'h0240, 7), 1'b0);
    cyc();

    cif.flush = 1'b1;
    lookup("flush_cyc", 1'b1, 14'h0243, 1'b1, beat(14'h0240, 3), 1'b0);
    cyc();
    lookup("flush_miss", 1'b1, 14'h0243, 1'b0, 32'd0, 1'b1);
    cyc();
    cif.flush  = 1'b0;
    cif.cpu_re = 1'b0;
    #1;
    chk("flush_norefill", 32'(mif.mem_req), 32'd0);
    cyc();

    miss("slow", 14'h0845);
    fill(14'h0840, 5, 2, -1, -1);
    for (int k = 0; k < 8; k++) begin
      lookup("slow_rd", 1'b1, 14'h0840 + 14'(k), 1'b1, beat(14'h0840, k), 1'b0);
      cyc();
    end

    miss("fl", 14'h0043);
    fill(14'h0040, 0, 0, 3, -1);
    lookup("fl_pend_clr", 1'b0, 14'h0043, 1'b0, 32'd0, 1'b0);
    lookup("fl_remiss", 1'b1, 14'h0043, 1'b0, 32'd0, 1'b1);
    cyc();

    fill(14'h0040, 0, 0, -1, 4);
    #1;
    chk("midrst_req", 32'(mif.mem_req), 32'd0);
    chk("midrst_hit", 32'(cif.cpu_hit), 32'd0);
    reset      = 1'b0;
    cif.cpu_re = 1'b0;
    cyc();
    miss("post_rst", 14'h0043);
    fill(14'h0040, 0, 0, -1, -1);
    for (int k = 0; k < 8; k++) begin
      lookup("post_rst_rd", 1'b1, 14'h0040 + 14'(k), 1'b1, 32'hA0 + 32'(k), 1'b0);
      cyc();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
